// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU control/datapath with valid/ready ROM and RAM ports.
// Define HACK_CPU_INSTRET_EN to add the retired-instruction counter port instret_o.

module hack_alu (
   input  logic [15:0] x_i,
   input  logic [15:0] y_i,
   input  logic        zx_i,
   input  logic        nx_i,
   input  logic        zy_i,
   input  logic        ny_i,
   input  logic        f_i,
   input  logic        no_i,
   output logic [15:0] out_o,
   output logic        zr_o,
   output logic        ng_o
);
   logic [15:0] x_d, y_d, r_d;

   always_comb begin
      x_d = zx_i ? 16'h0000 : x_i;
      x_d = nx_i ? ~x_d : x_d;
      y_d = zy_i ? 16'h0000 : y_i;
      y_d = ny_i ? ~y_d : y_d;
      r_d = f_i ? (x_d + y_d) : (x_d & y_d);
      out_o = no_i ? ~r_d : r_d;
   end

   assign zr_o = (out_o == 16'h0000);
   assign ng_o = out_o[15];
endmodule

module hack_inc16 (
   input  logic [15:0] in_i,
   output logic [15:0] out_o
);
   assign out_o = in_i + 16'd1;
endmodule

// state   | meaning
// FETCH   | instr_req high, wait for instr_valid, latch IR
// MREAD   | mem_re high at A, wait for mem_ready, latch M
// EXEC    | one cycle: ALU result to A/D, PC update, maybe start write
// MWRITE  | mem_we high at old A, wait for mem_ready
module hack_cpu_core #(
   parameter int                ADDR_W   = 15,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   input  logic              instr_valid_i,
   input  logic [15:0]       instr_data_i,
   output logic              mem_re_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [15:0]       mem_wdata_o,
   input  logic [15:0]       mem_rdata_i,
   input  logic              mem_ready_i,
`ifdef HACK_CPU_INSTRET_EN
   output logic [31:0]       instret_o,
`endif
   output logic [ADDR_W-1:0] pc_out_o
);
   typedef enum logic [1:0] {S_FETCH, S_MREAD, S_EXEC, S_MWRITE} state_t;

   state_t            state_q;
   logic [15:0]       a_q, d_q, ir_q, m_q, mem_wdata_q;
   logic [ADDR_W-1:0] pc_q, mem_addr_q, pc_d;
   logic              instr_req_q, mem_re_q, mem_we_q;

   logic        is_c, dst_a, dst_d, dst_m, jump;
   logic [15:0] alu_out, inc_out;
   logic        alu_zr, alu_ng;
   logic        unused_inc;

   assign is_c  = ir_q[15];
   assign dst_a = is_c & ir_q[5];
   assign dst_d = is_c & ir_q[4];
   assign dst_m = is_c & ir_q[3];
   assign jump  = is_c & ((ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) |
                          (ir_q[0] & ~alu_ng & ~alu_zr));

   hack_alu u_alu (
      .x_i   (d_q),
      .y_i   (ir_q[12] ? m_q : a_q),
      .zx_i  (ir_q[11]),
      .nx_i  (ir_q[10]),
      .zy_i  (ir_q[9]),
      .ny_i  (ir_q[8]),
      .f_i   (ir_q[7]),
      .no_i  (ir_q[6]),
      .out_o (alu_out),
      .zr_o  (alu_zr),
      .ng_o  (alu_ng)
   );

   hack_inc16 u_inc (
      .in_i  (16'(pc_q)),
      .out_o (inc_out)
   );

   // Truncating the incrementer output gives the modulo-2^ADDR_W PC wrap.
   assign unused_inc = inc_out[15];
   assign pc_d = jump ? a_q[ADDR_W-1:0] : inc_out[ADDR_W-1:0];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_FETCH;
         a_q         <= '0;
         d_q         <= '0;
         pc_q        <= RESET_PC;
         ir_q        <= '0;
         m_q         <= '0;
         instr_req_q <= 1'b1;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            S_FETCH: begin
               if (instr_valid_i) begin
                  ir_q        <= instr_data_i;
                  instr_req_q <= 1'b0;
                  if (instr_data_i[15] && instr_data_i[12]) begin
                     state_q    <= S_MREAD;
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= a_q[ADDR_W-1:0];
                  end else begin
                     state_q <= S_EXEC;
                  end
               end
            end
            S_MREAD: begin
               if (mem_ready_i) begin
                  m_q        <= mem_rdata_i;
                  mem_re_q   <= 1'b0;
                  mem_addr_q <= '0;
                  state_q    <= S_EXEC;
               end
            end
            S_EXEC: begin
               pc_q <= pc_d;
               if (!is_c) a_q <= {1'b0, ir_q[14:0]};
               else if (dst_a) a_q <= alu_out;
               if (dst_d) d_q <= alu_out;
               // Write address is the pre-instruction A, even if A is also a destination.
               if (dst_m) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= a_q[ADDR_W-1:0];
                  mem_wdata_q <= alu_out;
                  state_q     <= S_MWRITE;
               end else begin
                  instr_req_q <= 1'b1;
                  state_q     <= S_FETCH;
               end
            end
            S_MWRITE: begin
               if (mem_ready_i) begin
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  instr_req_q <= 1'b1;
                  state_q     <= S_FETCH;
               end
            end
            default: begin
               state_q     <= S_FETCH;
               instr_req_q <= 1'b1;
               mem_re_q    <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= '0;
            end
         endcase
      end
   end

`ifdef HACK_CPU_INSTRET_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) instret_q <= '0;
      else if ((state_q == S_EXEC && !dst_m) || (state_q == S_MWRITE && mem_ready_i))
         instret_q <= instret_q + 32'd1;
   end

   assign instret_o = instret_q;
`endif

   assign instr_req_o  = instr_req_q;
   assign instr_addr_o = pc_q;
   assign mem_re_o     = mem_re_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign pc_out_o     = pc_q;
endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed bench for hack_cpu_core: ROM/RAM models with programmable wait states.
// Covers the instret_o port when HACK_CPU_INSTRET_EN is defined.

module tb_hack_cpu_core;
   logic        clk_i = 1'b0;
   logic        reset_i = 1'b1;
   logic        instr_req_o;
   logic [14:0] instr_addr_o;
   logic        instr_valid_i = 1'b0;
   logic [15:0] instr_data_i = '0;
   logic        mem_re_o, mem_we_o;
   logic [14:0] mem_addr_o;
   logic [15:0] mem_wdata_o;
   logic [15:0] mem_rdata_i = '0;
   logic        mem_ready_i = 1'b0;
   logic [14:0] pc_out_o;
`ifdef HACK_CPU_INSTRET_EN
   logic [31:0] instret_o;
`endif

   hack_cpu_core dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .instr_req_o  (instr_req_o),
      .instr_addr_o (instr_addr_o),
      .instr_valid_i(instr_valid_i),
      .instr_data_i (instr_data_i),
      .mem_re_o     (mem_re_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_ready_i  (mem_ready_i),
`ifdef HACK_CPU_INSTRET_EN
      .instret_o    (instret_o),
`endif
      .pc_out_o     (pc_out_o)
   );

   always #5 clk_i = ~clk_i;

   logic [15:0] rom [0:32767];
   logic [15:0] ram [0:32767];
   int rom_wait, ram_wait, rom_cnt, ram_cnt;
   int fetch_cnt, cyc, re_cycles, we_cycles, wr_cnt, viol, wdata_unstable;
   logic [14:0] log_addr [0:15];
   int          acc_cyc  [0:15];
   logic [14:0] re_addr, wr_addr;
   logic [15:0] wr_data, we_data0;
   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: advance to the falling edge, watch the bus, drive ROM/RAM responses.
   task automatic step();
      @(negedge clk_i);
      cyc++;
      if (mem_re_o && mem_we_o) viol++;
      if (instr_req_o && (mem_re_o || mem_we_o)) viol++;
      if (!mem_re_o && !mem_we_o && mem_addr_o != 15'd0) viol++;
      if (reset_i) begin
         instr_valid_i = 1'b0;
         mem_ready_i   = 1'b0;
         rom_cnt = 0;
         ram_cnt = 0;
      end else begin
         if (instr_req_o) begin
            instr_data_i = rom[instr_addr_o];
            if (rom_cnt == rom_wait) begin
               instr_valid_i = 1'b1;
               rom_cnt = 0;
               if (fetch_cnt < 16) begin
                  log_addr[fetch_cnt] = instr_addr_o;
                  acc_cyc[fetch_cnt]  = cyc;
               end
               fetch_cnt++;
            end else begin
               instr_valid_i = 1'b0;
               rom_cnt++;
            end
         end else begin
            instr_valid_i = 1'b0;
            rom_cnt = 0;
         end
         if (mem_re_o || mem_we_o) begin
            if (mem_re_o) begin
               re_cycles++;
               re_addr = mem_addr_o;
            end
            if (mem_we_o) begin
               we_cycles++;
               if (we_cycles == 1) we_data0 = mem_wdata_o;
               else if (mem_wdata_o != we_data0) wdata_unstable++;
            end
            mem_rdata_i = ram[mem_addr_o];
            if (ram_cnt == ram_wait) begin
               mem_ready_i = 1'b1;
               ram_cnt = 0;
               if (mem_we_o) begin
                  ram[mem_addr_o] = mem_wdata_o;
                  wr_cnt++;
                  wr_addr = mem_addr_o;
                  wr_data = mem_wdata_o;
               end
            end else begin
               mem_ready_i = 1'b0;
               ram_cnt++;
            end
         end else begin
            mem_ready_i = 1'b0;
            ram_cnt = 0;
         end
      end
   endtask

   task automatic prep(input int rw, input int mw);
      for (int i = 0; i < 32768; i++) begin
         rom[i] = 16'h0000;
         ram[i] = 16'h0000;
      end
      rom_wait = rw;
      ram_wait = mw;
      reset_i = 1'b1;
      step();
      step();
      check("rst_req", instr_req_o, 1);
      check("rst_pc", pc_out_o, 0);
      check("rst_memif", {mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o}, 0);
      check("rst_ad", {dut.a_q, dut.d_q}, 0);
`ifdef HACK_CPU_INSTRET_EN
      check("rst_instret", instret_o, 0);
`endif
      reset_i = 1'b0;
      fetch_cnt = 0; re_cycles = 0; we_cycles = 0; wr_cnt = 0;
      wdata_unstable = 0;
   endtask

   // Run until instruction k+1 is being fetched, i.e. k instructions have retired.
   task automatic run_to(input int k);
      int n;
      n = 0;
      while (fetch_cnt < k + 1 && n < 400) begin
         step();
         n++;
      end
      if (n >= 400) check("run_timeout", fetch_cnt, k + 1);
   endtask

   task automatic jump_test(input string tag, input logic [15:0] i1, input logic [15:0] i2,
                            input logic [14:0] exp_pc);
      prep(0, 0);
      rom[0] = 16'h000A;
      rom[1] = i1;
      rom[2] = i2;
      run_to(3);
      check(tag, pc_out_o, exp_pc);
   endtask

   initial begin
      int n;
      cyc = 0; viol = 0;

      // @5, D=A, null instruction
      prep(0, 0);
      rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h8000;
      run_to(2);
      check("t1_a", dut.a_q, 16'h0005);
      check("t1_d", dut.d_q, 16'h0005);
      check("t1_pc", pc_out_o, 2);
      check("t1_seq", {log_addr[0], log_addr[1], log_addr[2]}, {15'd0, 15'd1, 15'd2});
      check("t1_lat", acc_cyc[2] - acc_cyc[0], 4);
      run_to(3);
      check("null_ad", {dut.a_q, dut.d_q}, {16'h0005, 16'h0005});
      check("null_pc", pc_out_o, 3);
      check("null_nowr", wr_cnt, 0);

      // D=M with 2 wait states, then M=D+1 with 2 wait states
      prep(0, 2);
      ram[7] = 16'h1234;
      rom[0] = 16'h0007; rom[1] = 16'hFC10; rom[2] = 16'hE7C8;
      run_to(2);
      check("rd_d", dut.d_q, 16'h1234);
      check("rd_pc", pc_out_o, 2);
      check("rd_cycles", re_cycles, 3);
      check("rd_addr", re_addr, 7);
      check("rd_lat", acc_cyc[2] - acc_cyc[1], 5);
      run_to(3);
      check("wr_cnt", wr_cnt, 1);
      check("wr_addr", wr_addr, 7);
      check("wr_data", wr_data, 16'h1235);
      check("wr_cycles", we_cycles, 3);
      check("wr_stable", wdata_unstable, 0);
      check("wr_ad", {dut.a_q, dut.d_q}, {16'h0007, 16'h1234});
      check("wr_pc", pc_out_o, 3);
      check("wr_lat", acc_cyc[3] - acc_cyc[2], 5);
`ifdef HACK_CPU_INSTRET_EN
      check("instret_3", instret_o, 3);
`endif

      jump_test("jeq_taken",  16'hEA90, 16'hE302, 15'd10);
      jump_test("jeq_not",    16'hEFD0, 16'hE302, 15'd3);
      jump_test("jlt_taken",  16'hEE90, 16'hE304, 15'd10);
      jump_test("jgt_taken",  16'hEFD0, 16'hE301, 15'd10);
      jump_test("jgt_zero",   16'hEA90, 16'hE301, 15'd3);
      // A=0;JMP must jump to the old A
      jump_test("jmp_aold",   16'hEA90, 16'hEAA7, 15'd10);
      check("jmp_aold_a", dut.a_q, 16'h0000);

      // PC wrap from 0x7FFF
      prep(0, 0);
      rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[15'h7FFF] = 16'h0003;
      run_to(3);
      check("wrap_jmp", log_addr[2], 15'h7FFF);
      check("wrap_addr", log_addr[3], 15'h0000);
      check("wrap_a", dut.a_q, 16'h0003);

      // Reset during a stalled write
      prep(1, 50);
      rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'hE7C8;
      n = 0;
      while (we_cycles < 2 && n < 200) begin
         step();
         n++;
      end
      check("mw_reached", (we_cycles >= 2), 1);
      reset_i = 1'b1;
      step();
      check("mw_rst_we", mem_we_o, 0);
      check("mw_rst_req", instr_req_o, 1);
      check("mw_rst_addr", instr_addr_o, 0);
      check("mw_rst_ad", {dut.a_q, dut.d_q}, 0);
      check("mw_rst_nowr", wr_cnt, 0);
`ifdef HACK_CPU_INSTRET_EN
      check("mw_rst_instret", instret_o, 0);
`endif
      reset_i = 1'b0;
      step();

      check("bus_rules", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
- Multi-cycle Hack-ISA control/datapath stage, directly upstream of the ALU: decodes 16-bit instructions, holds A/D/PC registers, drives ALU operands and control bits (zx,nx,zy,ny,f,no), consumes out/zr/ng.
- Fetches from instruction ROM and reads/writes data RAM over valid/ready handshakes, so it tolerates variable-latency memories.
- Instantiates the existing ALU and INC16 blocks.

Parameters:
- RESET_PC, 15'h0000, PC value loaded on reset.
- ADDR_W, 15, instruction and data address width. Data width is fixed at 16.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- instr_req  out  1  fetch request.
- instr_addr  out  ADDR_W  fetch address (= PC).
- instr_valid  in  1  instruction data valid. Sampled only while instr_req=1.
- instr_data  in  16  fetched instruction.
- mem_re  out  1  data read request.
- mem_we  out  1  data write request.
- mem_addr  out  ADDR_W  data address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- mem_ready  in  1  read/write completes this cycle. Sampled only while mem_re or mem_we is 1.
- pc_out  out  ADDR_W  current PC, for debug.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=FETCH, A=0, D=0, PC=RESET_PC, IR=0, mem_re=0, mem_we=0, mem_wdata=0.
  - instr_req=1 in the first cycle after reset.
  - Reset dominates every other event. An in-flight ROM/RAM transaction is abandoned and no register update occurs.
- Decode:
  - IR[15]=0 is an A-instruction.
  - IR[15]=1 is a C-instruction; bits 14:13 are ignored.
  - C-instruction fields: a=IR[12]; c=IR[11:6] maps to zx,nx,zy,ny,f,no; d=IR[5:3] maps to A,D,M; j=IR[2:0] maps to lt,eq,gt.
- ALU operands: x=D; y=(a ? M_latched : A).
- FSM states: FETCH, MREAD, EXEC, MWRITE.
- FETCH:
  - instr_req=1, instr_addr=PC, held stable until instr_valid.
  - On instr_valid: IR<=instr_data.
  - Next state: MREAD if C-instruction with a=1, otherwise EXEC.
- MREAD:
  - mem_re=1, mem_addr=A[ADDR_W-1:0], held until mem_ready.
  - On mem_ready: M_latched<=mem_rdata; go to EXEC.
- EXEC (exactly 1 cycle), A-instruction:
  - A<={1'b0,IR[14:0]}, PC<=PC+1, go to FETCH.
- EXEC (exactly 1 cycle), C-instruction:
  - jump = (lt&ng) | (eq&zr) | (gt&~ng&~zr).
  - PC <= jump ? A_old[ADDR_W-1:0] : PC+1.
  - If dA, A<=alu_out. If dD, D<=alu_out.
  - If dM: mem_wdata<=alu_out, waddr<=A_old; go to MWRITE. Otherwise go to FETCH.
  - A_old means the pre-instruction A value, used for both jump target and write address.
- MWRITE:
  - mem_we=1, mem_addr=waddr, mem_wdata held until mem_ready.
  - On mem_ready: go to FETCH.
- Latency:
  - A-instruction: 2 cycles minimum.
  - C-instruction: 2 cycles, +1 with M read, +1 with M write. Each memory wait adds cycles.
- Wrap-around: PC+1 wraps modulo 2^ADDR_W (0x7FFF -> 0x0000). ALU arithmetic is modulo 2^16.
- Mutual exclusion: mem_re and mem_we are never both 1. instr_req is 0 outside FETCH. mem_addr=0 when idle.
- Null instruction: 0x8000-class C-instruction with d=0 and j=0 updates only PC+1.

Optional Feature:
- Macro: HACK_CPU_INSTRET_EN.
- Defined:
  - Adds output instret [31:0], reset to 0.
  - Increments by 1 on the final cycle of each instruction: EXEC without write, or the MWRITE cycle with mem_ready.
  - Wraps at 2^32.
- Undefined: port and counter absent. Behaviour is otherwise identical.

Test Plan:
- Register writes: reset, ROM[0]=0x0005 (@5), ROM[1]=0xEC10 (D=A), ROM/RAM ready every cycle -> A=5, D=5, PC=2 after 4 cycles. instr_addr sequence 0,1,2.
- Delayed read: A=7, instr 0xFC10 (D=M), mem_ready asserted on the 3rd MREAD cycle with mem_rdata=0x1234 -> mem_re=1 with mem_addr=7 held 3 cycles; D=0x1234; PC+1.
- Write: A=7, D=0x1234, instr 0xE7C8 (M=D+1) -> mem_we=1, mem_addr=7, mem_wdata=0x1235 until mem_ready; D, A unchanged.
- Jumps:
  - A=10, D=0, instr 0xE302 (D;JEQ) -> PC=10.
  - Same with D=1 -> PC+1.
  - D=0xFFFF, instr 0xE304 (D;JLT) -> PC=10.
- PC wrap: PC=0x7FFF, non-jump instruction -> next instr_addr=0x0000.
- Reset mid-write: reset asserted during MWRITE with mem_ready=0 -> next cycle mem_we=0, instr_req=1, instr_addr=RESET_PC, A=D=0. Under HACK_CPU_INSTRET_EN, instret=0.
